array_8_ctrl: RTL and testbench

//  Sequencer for the 8x8 weight-stationary, binary-serial systolic array. Per job it drives:
//   - column-wise weight load;
//   - row-skewed bit-serial ifm streaming, with mac_done at each bit-period end;
//   - column-wise ofm drain.

---
 rtl/array_ctrl_pkg.sv | 17 +
 rtl/array_8_ctrl_if.sv | 40 ++++
 rtl/array_ctrl_rowgen.sv | 23 ++
 rtl/array_8_ctrl.sv | 144 ++++++++++++++
 tb/tb_array_8_ctrl.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/array_ctrl_pkg.sv
// Shared types and helpers for the 8x8 bit-serial systolic array sequencer.
package array_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CLR    = 3'd1,
      LOADW  = 3'd2,
      STREAM = 3'd3,
      DRAIN  = 3'd4,
      DONE   = 3'd5
   } state_t;

   function automatic int cyc_of(input int idepth);
      return 1 << idepth;
   endfunction

endpackage

// File: rtl/array_8_ctrl_if.sv
// Job-side handshake plus array control pins of the sequencer.
// cyc_cnt exists only when ARRAY_CTRL_PERF_EN is defined.
interface array_8_ctrl_if #(
   parameter int HEIGHT = 8,
   parameter int WIDTH  = 8,
   parameter int VWIDTH = 16
);
   logic              start;
   logic              abort;
   logic [VWIDTH-1:0] num_vec;
   logic              busy;
   logic              done;
   logic              wght_rd;
   logic [HEIGHT-1:0] ifm_rd;
   logic              ofm_vld;
   logic [HEIGHT-1:0] en_i;
   logic [HEIGHT-1:0] clr_i;
   logic [HEIGHT-1:0] mac_done;
   logic [WIDTH-1:0]  en_w;
   logic [WIDTH-1:0]  clr_w;
   logic [WIDTH-1:0]  en_o;
   logic [WIDTH-1:0]  clr_o;
`ifdef ARRAY_CTRL_PERF_EN
   logic [31:0]       cyc_cnt;

   modport master (output start, abort, num_vec,
                   input  busy, done, wght_rd, ifm_rd, ofm_vld, en_i, clr_i, mac_done,
                          en_w, clr_w, en_o, clr_o, cyc_cnt);
   modport slave  (input  start, abort, num_vec,
                   output busy, done, wght_rd, ifm_rd, ofm_vld, en_i, clr_i, mac_done,
                          en_w, clr_w, en_o, clr_o, cyc_cnt);
`else
   modport master (output start, abort, num_vec,
                   input  busy, done, wght_rd, ifm_rd, ofm_vld, en_i, clr_i, mac_done,
                          en_w, clr_w, en_o, clr_o);
   modport slave  (input  start, abort, num_vec,
                   output busy, done, wght_rd, ifm_rd, ofm_vld, en_i, clr_i, mac_done,
                          en_w, clr_w, en_o, clr_o);
`endif
endinterface

// File: rtl/array_ctrl_rowgen.sv
// Per-row skew decode: row h streams during steps h..h+N-1 of the STREAM phase.
module array_ctrl_rowgen import array_ctrl_pkg::*; #(
   parameter int HEIGHT = 8,
   parameter int IDEPTH = 3,
   parameter int VWIDTH = 16
) (
   input  logic [VWIDTH:0]   step,
   input  logic [VWIDTH-1:0] n,
   input  logic [IDEPTH-1:0] bit_cnt,
   output logic [HEIGHT-1:0] active,
   output logic [HEIGHT-1:0] ifm_rd,
   output logic [HEIGHT-1:0] mac_done
);
   localparam logic [IDEPTH-1:0] BIT_LAST = IDEPTH'(cyc_of(IDEPTH) - 1);

   for (genvar h = 0; h < HEIGHT; h++) begin : g_row
      localparam logic [VWIDTH:0] HV = (VWIDTH+1)'(h);
      // One extra bit on step keeps h+N from wrapping.
      assign active[h]   = (step >= HV) && (step < HV + {1'b0, n});
      assign ifm_rd[h]   = active[h] && (bit_cnt == '0);
      assign mac_done[h] = active[h] && (bit_cnt == BIT_LAST);
   end
endmodule

// File: rtl/array_8_ctrl.sv
// Job sequencer for the 8x8 array: CLR -> LOADW -> STREAM -> DRAIN -> DONE.
// Optional busy-cycle counter cyc_cnt enabled by ARRAY_CTRL_PERF_EN.
module array_8_ctrl import array_ctrl_pkg::*; #(
   parameter int HEIGHT = 8,
   parameter int WIDTH  = 8,
   parameter int IDEPTH = 3,
   parameter int VWIDTH = 16
) (
   input logic           clk,
   input logic           rst_n,
   array_8_ctrl_if.slave bus
);
   localparam logic [2:0] S_IDLE   = IDLE;
   localparam logic [2:0] S_CLR    = CLR;
   localparam logic [2:0] S_LOADW  = LOADW;
   localparam logic [2:0] S_STREAM = STREAM;
   localparam logic [2:0] S_DRAIN  = DRAIN;
   localparam logic [2:0] S_DONE   = DONE;

   localparam int              CYC      = cyc_of(IDEPTH);
   localparam int              RW       = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
   localparam logic [RW-1:0]   ROW_LAST = RW'(HEIGHT - 1);
   localparam logic [IDEPTH-1:0] BIT_LAST = IDEPTH'(CYC - 1);
   localparam logic [VWIDTH:0] SKEW     = (VWIDTH+1)'(HEIGHT - 2);

   logic [2:0]        state_q, state_nx;
   logic [VWIDTH-1:0] n_q;
   logic [RW-1:0]     row_q, row_nx;
   logic [IDEPTH-1:0] bit_q, bit_nx;
   logic [VWIDTH:0]   step_q, step_nx;
   logic              accept, abort_hit, clr_all;
   logic [HEIGHT-1:0] active, ifm_rd_nx, mac_done_nx;

   always_comb begin
      state_nx  = state_q;
      row_nx    = row_q;
      bit_nx    = bit_q;
      step_nx   = step_q;
      accept    = 1'b0;
      abort_hit = bus.abort && (state_q != S_IDLE);
      if (abort_hit) begin
         state_nx = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: if (bus.start) begin
               accept   = 1'b1;
               state_nx = S_CLR;
            end
            S_CLR: begin
               row_nx   = '0;
               state_nx = (n_q == '0) ? S_DONE : S_LOADW;
            end
            S_LOADW: if (row_q == ROW_LAST) begin
               state_nx = S_STREAM;
               bit_nx   = '0;
               step_nx  = '0;
            end else begin
               row_nx = row_q + 1'b1;
            end
            S_STREAM: begin
               bit_nx = bit_q + 1'b1;
               if (bit_q == BIT_LAST) begin
                  if (step_q == {1'b0, n_q} + SKEW) begin
                     state_nx = S_DRAIN;
                     row_nx   = '0;
                  end else begin
                     step_nx = step_q + 1'b1;
                  end
               end
            end
            S_DRAIN: if (row_q == ROW_LAST) state_nx = S_DONE;
                     else                   row_nx   = row_q + 1'b1;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
         endcase
      end
   end

   array_ctrl_rowgen #(.HEIGHT(HEIGHT), .IDEPTH(IDEPTH), .VWIDTH(VWIDTH)) u_rowgen (
      .step     (step_nx),
      .n        (n_q),
      .bit_cnt  (bit_nx),
      .active   (active),
      .ifm_rd   (ifm_rd_nx),
      .mac_done (mac_done_nx)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         n_q     <= '0;
         row_q   <= '0;
         bit_q   <= '0;
         step_q  <= '0;
      end else begin
         state_q <= state_nx;
         row_q   <= row_nx;
         bit_q   <= bit_nx;
         step_q  <= step_nx;
         if (accept) n_q <= bus.num_vec;
      end
   end

   // Outputs are registered from the next state, so they line up with state_q.
   assign clr_all = (state_nx == S_CLR) || abort_hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
         bus.wght_rd  <= 1'b0;
         bus.ifm_rd   <= '0;
         bus.ofm_vld  <= 1'b0;
         bus.en_i     <= '0;
         bus.clr_i    <= '0;
         bus.mac_done <= '0;
         bus.en_w     <= '0;
         bus.clr_w    <= '0;
         bus.en_o     <= '0;
         bus.clr_o    <= '0;
      end else begin
         bus.busy     <= (state_nx != S_IDLE);
         bus.done     <= (state_nx == S_DONE);
         bus.wght_rd  <= (state_nx == S_LOADW);
         bus.en_w     <= {WIDTH{state_nx == S_LOADW}};
         bus.en_i     <= (state_nx == S_STREAM) ? active      : '0;
         bus.ifm_rd   <= (state_nx == S_STREAM) ? ifm_rd_nx   : '0;
         bus.mac_done <= (state_nx == S_STREAM) ? mac_done_nx : '0;
         bus.ofm_vld  <= (state_nx == S_DRAIN);
         bus.en_o     <= {WIDTH{state_nx == S_DRAIN}};
         bus.clr_i    <= {HEIGHT{clr_all}};
         bus.clr_w    <= {WIDTH{clr_all}};
         bus.clr_o    <= {WIDTH{clr_all}};
      end
   end

`ifdef ARRAY_CTRL_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  bus.cyc_cnt <= '0;
      else if (accept)             bus.cyc_cnt <= '0;
      else if (state_q != S_IDLE)  bus.cyc_cnt <= bus.cyc_cnt + 32'd1;
   end
`endif
endmodule

// File: tb/tb_array_8_ctrl.sv
// Directed bench for array_8_ctrl at HEIGHT=WIDTH=8, IDEPTH=3 (8 cycles per MAC).
module tb_array_8_ctrl;
   localparam int H = 8, W = 8, ID = 3, VW = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   array_8_ctrl_if #(.HEIGHT(H), .WIDTH(W), .VWIDTH(VW)) bus ();
   array_8_ctrl #(.HEIGHT(H), .WIDTH(W), .IDEPTH(ID), .VWIDTH(VW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int failures = 0;
   localparam logic [67:0] ABORT_OUTS = {44'h0, 24'hFFFFFF};

   function automatic logic [67:0] outs();
      return {bus.busy, bus.done, bus.wght_rd, bus.ofm_vld, bus.ifm_rd, bus.en_i, bus.mac_done,
              bus.en_w, bus.en_o, bus.clr_i, bus.clr_w, bus.clr_o};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic [VW-1:0] n);
      bus.num_vec = n;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if (outs() !== '0) begin failures++; $display("FAIL reset_outs got=%h exp=0", outs()); end
`ifdef ARRAY_CTRL_PERF_EN
      checks++;
      if (bus.cyc_cnt !== 32'd0) begin failures++; $display("FAIL reset_cyc got=%0d exp=0", bus.cyc_cnt); end
`endif
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      tick();
      checks++;
      if (outs() !== '0) begin failures++; $display("FAIL idle_outs got=%h exp=0", outs()); end
   endtask

   task automatic test_job4();
      int wr_cnt = 0, wr_first = -1, vld_cnt = 0, done_cnt = 0, done_at = -1;
      int s0 = -1, md7_last = -1;
      logic busy_at_done = 1'b0;
      int ifm_cnt[H];
      int ifm_first[H];
      for (int h = 0; h < H; h++) begin ifm_cnt[h] = 0; ifm_first[h] = -1; end
      launch(16'd4);
      checks++;
      if (bus.busy !== 1'b1) begin failures++; $display("FAIL job4_busy_rise got=%b exp=1", bus.busy); end
      checks++;
      if ({bus.clr_i, bus.clr_w, bus.clr_o, bus.en_i, bus.en_w, bus.en_o} !== {24'hFFFFFF, 24'h0})
         begin failures++; $display("FAIL job4_clr got=%h exp=ffffff000000", {bus.clr_i, bus.clr_w, bus.clr_o, bus.en_i, bus.en_w, bus.en_o}); end
      for (int c = 1; c <= 112; c++) begin
         tick();
         if (bus.wght_rd) begin wr_cnt++; if (wr_first < 0) wr_first = c; end
         if (bus.ofm_vld) vld_cnt++;
         if (bus.en_i != '0 && s0 < 0) s0 = c;
         if (bus.mac_done[7]) md7_last = c;
         if (bus.done) begin done_cnt++; done_at = c; busy_at_done = bus.busy; end
         for (int h = 0; h < H; h++)
            if (bus.ifm_rd[h]) begin ifm_cnt[h]++; if (ifm_first[h] < 0) ifm_first[h] = c; end
      end
      checks++;
      if (wr_cnt !== 8 || wr_first !== 1) begin failures++; $display("FAIL job4_wght_rd got=%0d@%0d exp=8@1", wr_cnt, wr_first); end
      checks++;
      if (s0 !== 9) begin failures++; $display("FAIL job4_stream_start got=%0d exp=9", s0); end
      for (int h = 0; h < H; h++) begin
         checks++;
         if (ifm_cnt[h] !== 4 || ifm_first[h] !== 9 + 8*h)
            begin failures++; $display("FAIL job4_ifm_rd[%0d] got=%0d@%0d exp=4@%0d", h, ifm_cnt[h], ifm_first[h], 9 + 8*h); end
      end
      checks++;
      if (md7_last - s0 !== 87) begin failures++; $display("FAIL job4_md7_last got=%0d exp=87", md7_last - s0); end
      checks++;
      if (vld_cnt !== 8) begin failures++; $display("FAIL job4_ofm_vld got=%0d exp=8", vld_cnt); end
      checks++;
      if (done_cnt !== 1 || done_at !== 105 || busy_at_done !== 1'b1)
         begin failures++; $display("FAIL job4_done got=%0d@%0d busy=%b exp=1@105 busy=1", done_cnt, done_at, busy_at_done); end
      checks++;
      if (bus.busy !== 1'b0) begin failures++; $display("FAIL job4_idle got=%b exp=0", bus.busy); end
`ifdef ARRAY_CTRL_PERF_EN
      checks++;
      if (bus.cyc_cnt !== 32'd106) begin failures++; $display("FAIL job4_cyc_cnt got=%0d exp=106", bus.cyc_cnt); end
`endif
   endtask

   task automatic test_one_vec();
      logic [7:0] e_en, e_md;
      int done_at = -1;
      launch(16'd1);
      for (int c = 1; c <= 85; c++) begin
         tick();
         e_en = (c >= 9 && c <= 72) ? 8'(1 << ((c - 9) / 8)) : 8'h00;
         e_md = ((c - 9) % 8 == 7) ? e_en : 8'h00;
         checks++;
         if ({bus.en_i, bus.mac_done} !== {e_en, e_md})
            begin failures++; $display("FAIL one_vec_c%0d got=%h exp=%h", c, {bus.en_i, bus.mac_done}, {e_en, e_md}); end
         if (bus.done) done_at = c;
      end
      checks++;
      if (done_at !== 81) begin failures++; $display("FAIL one_vec_done got=%0d exp=81", done_at); end
   endtask

   task automatic test_zero_vec();
      logic [23:0] en_seen = '0;
      launch(16'd0);
      en_seen |= {bus.en_w, bus.en_i, bus.en_o};
      checks++;
      if ({bus.busy, bus.clr_i, bus.clr_w, bus.clr_o} !== {1'b1, 24'hFFFFFF})
         begin failures++; $display("FAIL zero_clr got=%h exp=1ffffff", {bus.busy, bus.clr_i, bus.clr_w, bus.clr_o}); end
      tick();
      en_seen |= {bus.en_w, bus.en_i, bus.en_o};
      checks++;
      if ({bus.done, bus.busy, bus.clr_i} !== {2'b11, 8'h00})
         begin failures++; $display("FAIL zero_done got=%h exp=300", {bus.done, bus.busy, bus.clr_i}); end
      for (int c = 0; c < 3; c++) begin tick(); en_seen |= {bus.en_w, bus.en_i, bus.en_o}; end
      checks++;
      if (outs() !== '0) begin failures++; $display("FAIL zero_idle got=%h exp=0", outs()); end
      checks++;
      if (en_seen !== '0) begin failures++; $display("FAIL zero_en got=%h exp=0", en_seen); end
   endtask

   task automatic test_abort();
      int done_cnt = 0, done_at = -1;
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      checks++;
      if (outs() !== '0) begin failures++; $display("FAIL abort_idle got=%h exp=0", outs()); end
      launch(16'd4);
      for (int c = 1; c <= 35; c++) begin tick(); if (bus.done) done_cnt++; end
      checks++;
      if (bus.en_i !== 8'h0F) begin failures++; $display("FAIL abort_step3_en got=%h exp=0f", bus.en_i); end
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      checks++;
      if (outs() !== ABORT_OUTS) begin failures++; $display("FAIL abort_clr got=%h exp=%h", outs(), ABORT_OUTS); end
      bus.num_vec = 16'd2;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      checks++;
      if ({bus.busy, bus.clr_i, bus.en_i} !== {1'b1, 8'hFF, 8'h00})
         begin failures++; $display("FAIL abort_restart got=%h exp=1ff00", {bus.busy, bus.clr_i, bus.en_i}); end
      for (int c = 1; c <= 95; c++) begin
         tick();
         if (bus.done) begin done_cnt++; done_at = c; end
      end
      checks++;
      if (done_cnt !== 1 || done_at !== 89) begin failures++; $display("FAIL abort_done got=%0d@%0d exp=1@89", done_cnt, done_at); end
   endtask

   task automatic test_back_to_back();
      int done_cnt = 0, done_at = -1, md0 = 0, busy_cnt = 0;
      bus.num_vec = 16'd3;
      bus.start = 1'b1;
      tick();
      bus.num_vec = 16'd7;
      for (int c = 1; c <= 110; c++) begin
         tick();
         if (bus.busy) busy_cnt++;
         if (bus.mac_done[0]) md0++;
         if (bus.done) begin done_cnt++; done_at = c; bus.start = 1'b0; end
      end
      bus.start = 1'b0;
      checks++;
      if (done_cnt !== 1 || done_at !== 97) begin failures++; $display("FAIL b2b_done got=%0d@%0d exp=1@97", done_cnt, done_at); end
      checks++;
      if (md0 !== 3 || busy_cnt !== 97) begin failures++; $display("FAIL b2b_len got=md%0d busy%0d exp=md3 busy97", md0, busy_cnt); end
   endtask

   task automatic test_reset_drain();
      launch(16'd1);
      for (int c = 1; c <= 75; c++) tick();
      checks++;
      if ({bus.ofm_vld, bus.en_o} !== 9'h1FF) begin failures++; $display("FAIL rst_drain_pre got=%h exp=1ff", {bus.ofm_vld, bus.en_o}); end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (outs() !== '0) begin failures++; $display("FAIL rst_drain_outs got=%h exp=0", outs()); end
`ifdef ARRAY_CTRL_PERF_EN
      checks++;
      if (bus.cyc_cnt !== 32'd0) begin failures++; $display("FAIL rst_drain_cyc got=%0d exp=0", bus.cyc_cnt); end
`endif
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      tick();
      checks++;
      if (outs() !== '0) begin failures++; $display("FAIL rst_drain_after got=%h exp=0", outs()); end
   endtask

   initial begin
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.num_vec = '0;
      test_reset();
      test_job4();
      test_one_vec();
      test_zero_vec();
      test_abort();
      test_back_to_back();
      test_reset_drain();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
